// File: rtl/video_pkg.sv
// Shared video-pipeline constants and types for the pixel output path.
// Parameterised blocks default their geometry from here.
package video_pkg;

    localparam int NUM_ENGINES = 30;
    localparam int RBG_SIZE    = 24;
    localparam int X_SIZE      = 640;
    localparam int Y_SIZE      = 480;
    localparam int X_WIDTH     = 10;
    localparam int Y_WIDTH     = 9;

    typedef logic [RBG_SIZE-1:0] rgb_t;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

endpackage

// File: rtl/raster_counter.sv
// Raster position tracker: x/y advance one pixel per 'advance_i', wrapping at
// line and frame ends, with start-of-frame / end-of-line / end-of-frame flags.
module raster_counter
    import video_pkg::*;
#(
    parameter int X_SIZE  = video_pkg::X_SIZE,
    parameter int Y_SIZE  = video_pkg::Y_SIZE,
    parameter int X_WIDTH = video_pkg::X_WIDTH,
    parameter int Y_WIDTH = video_pkg::Y_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               advance_i,
    output logic [X_WIDTH-1:0] x_o,
    output logic [Y_WIDTH-1:0] y_o,
    output logic               sof_o,
    output logic               eol_o,
    output logic               eof_o
);

    logic [X_WIDTH-1:0] x_q, x_d;
    logic [Y_WIDTH-1:0] y_q, y_d;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (advance_i) begin
            if (eol_o) begin
                x_d = '0;
                y_d = eof_o ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o   = x_q;
    assign y_o   = y_q;
    assign sof_o = (x_q == '0) && (y_q == '0);
    assign eol_o = (x_q == X_WIDTH'(X_SIZE - 1));
    assign eof_o = eol_o && (y_q == Y_WIDTH'(Y_SIZE - 1));

endmodule

// File: rtl/pixel_stream_serializer.sv
// Serialises a batch of NUM_ENGINES parallel RGB pixels into a one-pixel-per-cycle
// video stream; the batch-ending pixel can accept the next batch with no bubble.
module pixel_stream_serializer
    import video_pkg::*;
#(
    parameter int NUM_ENGINES = video_pkg::NUM_ENGINES,
    parameter int RBG_SIZE    = video_pkg::RBG_SIZE,
    parameter int X_SIZE      = video_pkg::X_SIZE,
    parameter int Y_SIZE      = video_pkg::Y_SIZE,
    parameter int X_WIDTH     = video_pkg::X_WIDTH,
    parameter int Y_WIDTH     = video_pkg::Y_WIDTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [RBG_SIZE-1:0] rgb_val [NUM_ENGINES],
    output logic [RBG_SIZE-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_user,
    output logic                out_last,
    output logic                dbg_stream_o
);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // in_ready may depend on out_ready; out_valid never depends on in_valid.

    localparam int IDX_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [RBG_SIZE-1:0] buf_q [NUM_ENGINES];

    logic               in_hs, out_hs, batch_last;
    logic               sof, eol, eof;
    logic [X_WIDTH-1:0] x;
    logic [Y_WIDTH-1:0] y;
    logic               unused_raster;

    raster_counter #(
        .X_SIZE (X_SIZE),
        .Y_SIZE (Y_SIZE),
        .X_WIDTH(X_WIDTH),
        .Y_WIDTH(Y_WIDTH)
    ) u_raster (
        .clk      (clk),
        .reset    (reset),
        .advance_i(out_hs),
        .x_o      (x),
        .y_o      (y),
        .sof_o    (sof),
        .eol_o    (eol),
        .eof_o    (eof)
    );

    assign unused_raster = ^{x, y, eof};

    // A batch ends at its last entry or at the line end, whichever comes first;
    // entries past the line end are padding and are never shown.
    assign batch_last = (state_q == STREAM) && (eol || (idx_q == IDX_W'(NUM_ENGINES - 1)));
    assign out_hs     = out_valid && out_ready;
    assign in_hs      = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = STREAM;
            STREAM:  if (out_hs && batch_last && !in_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        out_valid    = (state_q == STREAM);
        in_ready     = (state_q == IDLE) || (out_ready && batch_last);
        out_user     = sof && out_valid;
        out_last     = eol && out_valid;
        out_data     = out_valid ? buf_q[idx_q] : '0;
        dbg_stream_o = (state_q == STREAM);
    end

    always_comb begin
        idx_d = idx_q;
        if (in_hs)       idx_d = '0;
        else if (out_hs) idx_d = idx_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (in_hs) begin
            for (int i = 0; i < NUM_ENGINES; i++) buf_q[i] <= rgb_val[i];
        end
    end

endmodule

// File: tb/tb_pixel_stream_serializer.sv
// Directed bench for pixel_stream_serializer with a 4-engine, 10x2 raster:
// covers reset, back-to-back batches, padding drop, backpressure, frame wrap, mid-stream reset.
module tb_pixel_stream_serializer;

    localparam int NE = 4;
    localparam int XS = 10;
    localparam int YS = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] rgb_val [NE];
    logic [23:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_user;
    logic        out_last;
    logic        dbg_stream;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ir_cnt = 0;
    int hs_cyc[$];
    logic [25:0] exp_q[$];
    int bx = 0;
    int by = 0;

    pixel_stream_serializer #(
        .NUM_ENGINES(NE),
        .RBG_SIZE   (24),
        .X_SIZE     (XS),
        .Y_SIZE     (YS),
        .X_WIDTH    (4),
        .Y_WIDTH    (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .rgb_val     (rgb_val),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_user    (out_user),
        .out_last    (out_last),
        .dbg_stream_o(dbg_stream)
    );

    // Clock
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard model: expected {user, last, data} following raster position.
    task automatic push_px(input logic [23:0] d);
        exp_q.push_back({(bx == 0 && by == 0), (bx == XS - 1), d});
        bx++;
        if (bx == XS) begin
            bx = 0;
            by = (by == YS - 1) ? 0 : by + 1;
        end
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && in_ready) ir_cnt++;
        if (!reset && out_valid && out_ready) begin
            hs_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("extra_pixel", exp_q.size(), 1);
            end else begin
                logic [25:0] e;
                e = exp_q.pop_front();
                chk("pix_data", out_data, e[23:0]);
                chk("pix_user", out_user, e[25]);
                chk("pix_last", out_last, e[24]);
            end
        end
    end

    // Drivers
    task automatic send_batch(input logic [23:0] p0, input logic [23:0] p1,
                              input logic [23:0] p2, input logic [23:0] p3);
        bit ok;
        rgb_val[0] = p0;
        rgb_val[1] = p1;
        rgb_val[2] = p2;
        rgb_val[3] = p3;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("send_timeout", in_ready, 1);
        else begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", out_valid, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int thru;
        reset     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < NE; i++) rgb_val[i] = 24'h777777;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_user", out_user, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_dbg", dbg_stream, 0);
        reset    = 1'b0;
        in_valid = 1'b0;

        // Line 0: back-to-back batches, last one padded
        for (int i = 1; i <= 10; i++) push_px(24'(i));
        send_batch(24'd1, 24'd2, 24'd3, 24'd4);
        chk("lat_valid", out_valid, 1);
        chk("lat_data", out_data, 24'd1);
        chk("lat_user", out_user, 1);
        send_batch(24'd5, 24'd6, 24'd7, 24'd8);
        send_batch(24'd9, 24'd10, 24'd99, 24'd99);
        wait_idle();
        chk("line0_count", hs_cyc.size(), 10);
        thru = (hs_cyc.size() >= 10) ? hs_cyc[9] - hs_cyc[0] : -1;
        chk("line0_no_bubble", thru, 9);
        chk("in_ready_pulses", ir_cnt, 3);

        // Line 1: stall on the batch-ending pixel with the next batch offered
        for (int i = 11; i <= 20; i++) push_px(24'(i));
        send_batch(24'd11, 24'd12, 24'd13, 24'd14);
        chk("l1_first_user", out_user, 0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        out_ready  = 1'b0;
        rgb_val[0] = 24'd15;
        rgb_val[1] = 24'd16;
        rgb_val[2] = 24'd17;
        rgb_val[3] = 24'd18;
        in_valid   = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, 24'd14);
            chk("stall_last", out_last, 0);
            chk("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        send_batch(24'd15, 24'd16, 24'd17, 24'd18);
        send_batch(24'd19, 24'd20, 24'd99, 24'd99);
        wait_idle();

        // Frame wrap, then reset after two pixels of the batch
        push_px(24'd21);
        push_px(24'd22);
        send_batch(24'd21, 24'd22, 24'd23, 24'd24);
        chk("wrap_user", out_user, 1);
        chk("wrap_data", out_data, 24'd21);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset     = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("mr_out_valid", out_valid, 0);
        chk("mr_in_ready", in_ready, 1);
        chk("mr_out_data", out_data, 0);
        reset     = 1'b0;
        out_ready = 1'b1;
        bx = 0;
        by = 0;

        for (int i = 31; i <= 34; i++) push_px(24'(i));
        send_batch(24'd31, 24'd32, 24'd33, 24'd34);
        chk("post_rst_user", out_user, 1);
        chk("post_rst_data", out_data, 24'd31);
        wait_idle();

        chk("sb_empty", exp_q.size(), 0);
        chk("hs_total", hs_cyc.size(), 26);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
